rvj1_wb_master: RTL and testbench

- Wishbone B4 classic initiator for the rvj1 SoC. It is the counterpart of the user-area Wishbone slave port.
- Converts a single-outstanding valid/ready request from the core or a DMA into one Wishbone bus cycle, then returns read data or an error as a one-cycle response pulse.
- Includes a bus watchdog, so a non-responding slave aborts with an error instead of hanging the core.

---
 rtl/rvj1_wb_pkg.sv | 28 ++
 rtl/rvj1_wb_watchdog.sv | 40 ++++
 rtl/rvj1_wb_master.sv | 130 +++++++++++++
 tb/tb_rvj1_wb_master.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rvj1_wb_pkg.sv
// Shared Wishbone definitions for the rvj1 SoC: default widths, the initiator
// FSM encoding and request/response payloads reused by the DMA and slaves.
package rvj1_wb_pkg;

    localparam int unsigned WB_ADDR_W          = 32;
    localparam int unsigned WB_DATA_W          = 32;
    localparam int unsigned WB_SEL_W           = WB_DATA_W / 8;
    localparam int unsigned WB_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] wdata;
        logic [WB_SEL_W-1:0]  sel;
    } wb_req_t;

    typedef struct packed {
        logic                 err;
        logic [WB_DATA_W-1:0] rdata;
    } wb_rsp_t;

endpackage

// File: rtl/rvj1_wb_watchdog.sv
// Bus watchdog: counts cycles while enabled, saturating at TIMEOUT_CYCLES-1,
// where expired_c_o is raised.
module rvj1_wb_watchdog
    import rvj1_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_c_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Saturates at the expiry value so the count can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_c_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rvj1_wb_master.sv
// Wishbone B4 classic initiator: turns one valid/ready request into a single
// bus cycle and returns a one-cycle response, aborting via watchdog on timeout.
module rvj1_wb_master
    import rvj1_wb_pkg::*;
#(
    parameter int unsigned ADDR_W         = WB_ADDR_W,
    parameter int unsigned DATA_W         = WB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_sel_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i
);

    localparam int unsigned SEL_W = DATA_W / 8;

    wb_state_e         state_q;
    logic              ready_q;
    logic              cyc_q;
    logic              we_q;
    logic [SEL_W-1:0]  sel_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic              accept_c;
    logic              wd_expired_c;

    assign accept_c = (state_q == ST_IDLE) && ready_q && req_valid_i;

    rvj1_wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .clr_i       (accept_c),
        .en_i        (state_q == ST_BUS),
        .expired_c_o (wd_expired_c)
    );

    // ready_q is held low through reset and rises on the first edge after it,
    // otherwise it mirrors "state is IDLE".
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept_c) begin
                        we_q    <= req_we_i;
                        adr_q   <= req_addr_i;
                        dat_q   <= req_wdata_i;
                        sel_q   <= req_sel_i;
                        cyc_q   <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Slave ERR beats ACK, and any slave reply beats the watchdog.
                    if (wbm_err_i || wbm_ack_i || wd_expired_c) begin
                        cyc_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                        if (wbm_err_i) begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (wbm_ack_i) begin
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= we_q ? '0 : wbm_dat_i;
                        end else begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_rvj1_wb_master.sv
// Scoreboard bench for rvj1_wb_master: stimulus pushes expected responses,
// a negedge monitor pops and compares every rsp_valid_o pulse.
module tb_rvj1_wb_master;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_sel = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cyc, stb, wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack = 1'b0;
    logic        wbm_err = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [32:0] sb_q[$];

    rvj1_wb_master #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_sel_i   (req_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack),
        .wbm_err_i   (wbm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got err=%0b rdata=0x%0h expected no response",
                         rsp_err, rsp_rdata);
            end else begin
                logic [32:0] exp;
                exp = sb_q.pop_front();
                if ({rsp_err, rsp_rdata} !== exp) begin
                    n_fail++;
                    $display("FAIL rsp_payload: got err=%0b rdata=0x%0h expected err=%0b rdata=0x%0h",
                             rsp_err, rsp_rdata, exp[32], exp[31:0]);
                end
            end
        end
    end

    // mode: 0 ACK, 1 ERR, 2 ACK+ERR, 3 silent slave
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] sel, input int waits,
                       input int mode, input logic [31:0] sdat,
                       input logic exp_err, input logic [31:0] exp_rdata, input int exp_stb);
        int guard;
        int stb_cnt;
        bit ok_fields;
        sb_q.push_back({exp_err, exp_rdata});
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_sel = sel;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_accept"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        stb_cnt = 0;
        ok_fields = 1'b1;
        @(negedge clk);
        while (cyc && stb_cnt < 100) begin
            if (wbm_adr !== addr || wbm_sel !== sel || wbm_we !== we || stb !== cyc ||
                (we && wbm_dat_o !== wdata))
                ok_fields = 1'b0;
            if (mode != 3 && stb_cnt == waits) begin
                wbm_ack   = (mode == 0 || mode == 2);
                wbm_err   = (mode == 1 || mode == 2);
                wbm_dat_i = sdat;
            end
            @(posedge clk);
            #1 wbm_ack = 1'b0; wbm_err = 1'b0; wbm_dat_i = '0;
            stb_cnt++;
            @(negedge clk);
        end
        check({tag, "_bus_fields"}, 32'(ok_fields), 32'd1);
        check({tag, "_stb_cycles"}, 32'(stb_cnt), 32'(exp_stb));
        check({tag, "_rsp_latency"}, 32'(rsp_valid), 32'd1);
        check({tag, "_ready_in_resp"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int acc_t[3];
        int n_acc;
        int n_ack;
        bit quiet;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_rsp", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        #1 check("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ready_first_edge", 32'(req_ready), 32'd1);

        txn("zw_read", 1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 0, 32'hCAFE_F00D,
            1'b0, 32'hCAFE_F00D, 1);
        txn("wr_3ws", 1'b1, 32'h3000_0010, 32'h1234_5678, 4'h3, 3, 0, 32'hDEAD_BEEF,
            1'b0, 32'h0, 4);
        txn("slv_err", 1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 1, 32'h5555_AAAA,
            1'b1, 32'h0, 2);
        txn("ack_err", 1'b0, 32'h3000_0024, 32'h0, 4'hF, 0, 2, 32'h7777_7777,
            1'b1, 32'h0, 1);
        txn("post_err", 1'b0, 32'h3000_0028, 32'h0, 4'h1, 2, 0, 32'h0000_00A5,
            1'b0, 32'h0000_00A5, 3);
        txn("timeout", 1'b0, 32'h3000_0030, 32'h0, 4'hF, 0, 3, 32'h0,
            1'b1, 32'h0, int'(TO));

        // Late ACK two cycles after the abort must be ignored
        wbm_ack = 1'b1; wbm_dat_i = 32'hBAD0_BAD0;
        @(posedge clk);
        #1 wbm_ack = 1'b0; wbm_dat_i = '0;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || cyc) quiet = 1'b0;
        end
        check("late_ack_ignored", 32'(quiet), 32'd1);

        // Back-to-back reads with valid held high
        sb_q.push_back({1'b0, 32'h1});
        sb_q.push_back({1'b0, 32'h2});
        sb_q.push_back({1'b0, 32'h3});
        n_acc = 0; n_ack = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3000_0040; req_sel = 4'hF;
        for (int c = 0; c < 14; c++) begin
            if (req_valid && req_ready && n_acc < 3) begin
                acc_t[n_acc] = c;
                n_acc++;
            end
            if (cyc) begin
                wbm_ack = 1'b1;
                wbm_dat_i = 32'(n_ack + 1);
                n_ack++;
            end
            @(posedge clk);
            #1 wbm_ack = 1'b0; wbm_dat_i = '0;
            if (n_acc == 3) req_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_accepts", 32'(n_acc), 32'd3);
        check("b2b_acks", 32'(n_ack), 32'd3);
        if (n_acc == 3) begin
            check("b2b_gap1", 32'(acc_t[1] - acc_t[0]), 32'd3);
            check("b2b_gap2", 32'(acc_t[2] - acc_t[1]), 32'd3);
        end

        // Reset asserted between edges while the slave is stalling
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3000_0050; req_sel = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid_bus_cyc", 32'(cyc), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cyc", 32'(cyc), 32'd0);
        check("async_rst_stb", 32'(stb), 32'd0);
        check("async_rst_rsp", 32'(rsp_valid), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        txn("post_rst_read", 1'b0, 32'h3000_0060, 32'h0, 4'hF, 1, 0, 32'h0BAD_CAFE,
            1'b0, 32'h0BAD_CAFE, 2);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
